iir_pole_sched: RTL and testbench

Serial scheduler for the 7-tap pole (feedback) section of the direct-form IIR filter. It time-multiplexes one 12x12 signed multiplier and one accumulator across all seven pole taps, which replaces the seven parallel multipliers. It accepts a strobed 12-bit sample, sequences the taps with a counter-driven FSM and emits a 26-bit result with a valid pulse. The result is bit-identical to the parallel pole sum. It sits between the sample-rate input stage and the IIR output adder. The system clock runs faster than the sample rate.

---
 rtl/iir_pole_sched_pkg.sv | 20 ++
 rtl/iir_pole_sched_if.sv | 16 +
 rtl/iir_pole_sched_pole_tap_mac.sv | 52 +++++
 rtl/iir_pole_sched.sv | 97 +++++++++
 tb/tb_iir_pole_sched.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/iir_pole_sched_pkg.sv
// Shared constants for the IIR pole section: pole coefficients, datapath widths
// and the serial scheduler state encoding.
package iir_pkg;
    localparam int NTAP = 7;
    localparam int DW   = 12;
    localparam int PW   = 23;
    localparam int OW   = 26;

    // Fixed by the filter design; |c| <= 1163 keeps every product inside PW bits.
    localparam logic signed [DW-1:0] POLE_COEF [0:NTAP-1] = '{
        -12'sd922, 12'sd1163, -12'sd811, 12'sd412, -12'sd122, 12'sd24, -12'sd2
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/iir_pole_sched_if.sv
// Sample-in / result-out bundle of the pole scheduler. The producer/consumer
// side uses master, the scheduler uses slave.
interface iir_pole_sched_if #(
    parameter int DW = 12,
    parameter int OW = 26
);
    logic                 yin_valid;
    logic signed [DW-1:0] yin;
    logic signed [OW-1:0] yout;
    logic                 yout_valid;
    logic                 busy;
    logic                 ovr;

    modport master (output yin_valid, yin, input yout, yout_valid, busy, ovr);
    modport slave  (input yin_valid, yin, output yout, yout_valid, busy, ovr);
endinterface

// File: rtl/iir_pole_sched_pole_tap_mac.sv
// Shared signed multiplier plus 26-bit accumulator for the serial pole sum.
// IIR_POLE_SCHED_MULT_PIPE_EN registers the product before accumulation.
module pole_tap_mac #(
    parameter int DW = 12,
    parameter int OW = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] coef_i,
    input  logic signed [DW-1:0] samp_i,
    output logic signed [OW-1:0] acc_o
);
    localparam int PW = 2*DW - 1;

    logic signed [PW-1:0] prod;
    logic signed [OW-1:0] acc_q, addend;
    logic                 add_en;

    assign prod = PW'(coef_i) * PW'(samp_i);

`ifdef IIR_POLE_SCHED_MULT_PIPE_EN
    logic signed [PW-1:0] prod_q;
    logic                 en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            en_q   <= 1'b0;
        end else begin
            prod_q <= prod;
            en_q   <= clr_i ? 1'b0 : en_i;
        end
    end

    assign addend = OW'(prod_q);
    assign add_en = en_q;
`else
    assign addend = OW'(prod);
    assign add_en = en_i;
`endif

    // No saturation: seven worst-case products cannot exceed the OW range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      acc_q <= '0;
        else if (clr_i)  acc_q <= '0;
        else if (add_en) acc_q <= acc_q + addend;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/iir_pole_sched.sv
// Serial scheduler for the 7-tap IIR pole section: one multiplier walks the taps.
// Optional IIR_POLE_SCHED_MULT_PIPE_EN adds a product register and a DRAIN state.
module iir_pole_sched #(
    parameter int NTAP = 7,
    parameter int DW   = 12,
    parameter int OW   = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    iir_pole_sched_if.slave  bus
);
    import iir_pkg::*;

    localparam int            TW   = $clog2(NTAP);
    localparam logic [TW-1:0] LAST = TW'(NTAP - 1);

    state_e                     state_q, state_d;
    logic [TW-1:0]              tap_q, tap_d;
    logic [NTAP-1:0][DW-1:0]    yreg_q;
    logic signed [OW-1:0]       acc, yout_q;
    logic                       yout_vld_q;
    logic                       busy, mac_en, done, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = MAC;
                tap_d   = '0;
            end
            MAC: begin
                if (tap_q == LAST) begin
`ifdef IIR_POLE_SCHED_MULT_PIPE_EN
                    state_d = DRAIN;
`else
                    state_d = DONE;
`endif
                end else begin
                    tap_d = tap_q + TW'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        mac_en = (state_q == MAC);
        done   = (state_q == DONE);
    end

    assign accept = bus.yin_valid && !busy;

    // Element 0 holds the newest sample; strobes while busy leave the line alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      yreg_q <= '0;
        else if (accept) yreg_q <= {yreg_q[NTAP-2:0], bus.yin};
    end

    pole_tap_mac #(.DW(DW), .OW(OW)) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .en_i   (mac_en),
        .coef_i (POLE_COEF[tap_q]),
        .samp_i ($signed(yreg_q[tap_q])),
        .acc_o  (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yout_q     <= '0;
            yout_vld_q <= 1'b0;
        end else begin
            if (done) yout_q <= acc;
            yout_vld_q <= done;
        end
    end

    assign bus.yout       = yout_q;
    assign bus.yout_valid = yout_vld_q;
    assign bus.busy       = busy;
    assign bus.ovr        = bus.yin_valid && busy;
endmodule

// File: tb/tb_iir_pole_sched.sv
// Scoreboard bench for iir_pole_sched: a tap-history model predicts each result
// and its arrival cycle; a separate monitor checks every yout_valid pulse.
module tb_iir_pole_sched;
`ifdef IIR_POLE_SCHED_MULT_PIPE_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    typedef struct {
        longint val;
        longint cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    iir_pole_sched_if #(.DW(12), .OW(26)) bus ();

    iir_pole_sched #(.NTAP(7), .DW(12), .OW(26)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     coef [7] = '{-922, 1163, -811, 412, -122, 24, -2};
    int     hist [7];
    exp_t   expq [$];
    longint free_cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    bit     prev_vld = 1'b0;

    function automatic void check(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    endfunction

    function automatic longint model_sum();
        longint s = 0;
        for (int k = 0; k < 7; k++) s += longint'(coef[k]) * longint'(hist[k]);
        return s;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 7; k++) hist[k] = 0;
        expq.delete();
        free_cyc = 0;
    endfunction

    // One clock cycle of stimulus; cycle c is driven at the negedge at time 10c.
    task automatic drive(input bit v, input int d);
        longint cyc;
        bit     busy_e;
        @(negedge clk);
        cyc = $time / 10;
        bus.yin_valid = v;
        bus.yin       = d[11:0];
        busy_e = (cyc < free_cyc);
        #2;
        check("busy", bus.busy, busy_e);
        check("ovr", bus.ovr, v && busy_e);
        if (v && !busy_e) begin
            for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = d;
            expq.push_back('{model_sum(), cyc + LAT});
            free_cyc = cyc + LAT;
        end
    endtask

    function automatic int rnd12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        longint mcyc;
        mcyc = $time / 10;
        if (bus.yout_valid) begin
            check("yout_valid_gap", prev_vld, 0);
            if (expq.size() == 0) begin
                check("spurious_yout_valid", bus.yout_valid, 0);
            end else begin
                e = expq.pop_front();
                check("yout", bus.yout, e.val);
                check("yout_cycle", mcyc, e.cyc);
            end
        end
        prev_vld = bus.yout_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before t=1000000");
        $fatal(1);
    end

    initial begin
        bus.yin_valid = 1'b0;
        bus.yin       = '0;
        model_clear();
        #3;
        check("rst_yout", bus.yout, 0);
        check("rst_yout_valid", bus.yout_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ovr", bus.ovr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Impulse response, one sample per LAT cycles (minimum legal spacing).
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i == 0) ? 1 : 0);
            repeat (LAT - 1) drive(1'b0, 0);
        end

        // Full-scale negative step settles at -258 * -2048.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, -2048);
            repeat (LAT - 1) drive(1'b0, 0);
        end
        repeat (3) drive(1'b0, 0);
        check("step_final", bus.yout, 528384);

        // Strobe every cycle: only one in LAT is taken, the rest overrun.
        repeat (60) drive(1'b1, rnd12());
        repeat (LAT + 2) drive(1'b0, 0);

        // Reset in the middle of MAC: everything clears, no result escapes.
        drive(1'b1, rnd12());
        repeat (3) drive(1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.yin_valid = 1'b0;
        model_clear();
        #1;
        check("midrst_yout", bus.yout, 0);
        check("midrst_yout_valid", bus.yout_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ovr", bus.ovr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, rnd12());
        repeat (LAT + 1) drive(1'b0, 0);

        // Random samples at legal rates, including the tightest spacing.
        repeat (1000) begin
            drive(1'b1, rnd12());
            repeat (LAT - 1 + int'($urandom_range(0, 2))) drive(1'b0, 0);
        end

        repeat (LAT + 3) drive(1'b0, 0);
        check("results_outstanding", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
